sobel_pipeline: RTL and testbench

Streaming Sobel edge detector for one raster-order image frame of WIDTH_P x HEIGHT_P pixels. Each input pixel is converted to 8-bit grayscale and filtered with a 3x3 Sobel kernel, using two line buffers. One edge-magnitude pixel is emitted per input pixel, replicated across all channels, with a valid/ready handshake on both sides. The block sits between a pixel source (camera/DMA) and a pixel sink (framebuffer/display).

---
 rtl/sobel_pipeline.sv | 240 ++++++++++++++++++++++++
 tb/tb_sobel_pipeline.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_pipeline.sv
// sobel_pipeline: streaming 3x3 Sobel edge detector for one raster-order frame.
//
// Each accepted pixel is reduced to 8-bit gray. It then passes through two line
// buffers and a 3x3 window. The result is |Gx|+|Gy|, saturated to 255, and that
// byte is replicated into every channel of the output pixel. Pixels on the
// frame border produce 0.
//
// Ports:
//   clk_i    : clock, rising edge
//   resetn_i : asynchronous active-low reset
//   valid_i  : input pixel valid
//   ready_o  : input pixel accepted this cycle (when valid_i is high)
//   pixel_i  : input pixel, CHANNELS_P bytes (R=[23:16], G=[15:8], B=[7:0])
//   valid_o  : output pixel valid
//   ready_i  : sink accepts the output pixel
//   pixel_o  : edge magnitude replicated into every channel byte
//   last_o   : high with the final output pixel of a frame
module sobel_pipeline #(
    parameter int WIDTH_P    = 640,
    parameter int HEIGHT_P   = 480,
    parameter int CHANNELS_P = 3
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [CHANNELS_P*8-1:0] pixel_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [CHANNELS_P*8-1:0] pixel_o,
    output logic                    last_o
);

    localparam int CW = $clog2(WIDTH_P);
    localparam int RW = $clog2(HEIGHT_P + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_P - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(HEIGHT_P + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t state, state_nx;

    logic          stall;
    logic          step;
    logic [7:0]    gray;
    logic [7:0]    new_pix;

    // Step position: where the pixel entering the window sits in the frame.
    // The flush continues into rows H and H+1 with dummy pixels.
    logic [CW-1:0] scol;
    logic [RW-1:0] srow;
    // Position of the window center, which trails the step position by W+1.
    logic [CW-1:0] ccol;
    logic [RW-1:0] crow;

    logic          primed;
    logic          frame_end;
    logic          center_border;
    logic          center_last;

    logic [7:0]    lb0 [WIDTH_P];
    logic [7:0]    lb1 [WIDTH_P];
    logic [7:0]    win [3][3];

    logic signed [11:0] gx, gy;
    logic [11:0]        abs_gx, abs_gy, mag_sum;
    logic [7:0]         mag;

    logic       v1, b1, l1;
    logic       v2, l2;
    logic [7:0] mag2;

    // ------------------------------------------------------------------
    // Gray conversion
    // ------------------------------------------------------------------
    generate
        if (CHANNELS_P == 3) begin : g_rgb
            logic [9:0] luma_sum;
            assign luma_sum = {2'b00, pixel_i[23:16]}
                            + {1'b0, pixel_i[15:8], 1'b0}
                            + {2'b00, pixel_i[7:0]};
            assign gray = 8'(luma_sum >> 2);
        end else begin : g_mono
            assign gray = pixel_i[7:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign stall = valid_o && !ready_i;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready_o  = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                ready_o = !stall;
                step    = !stall && valid_i;
                if (step && (srow == ROW_LAST) && (scol == COL_LAST)) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                step = !stall;
                if (step && frame_end) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Flush pixels only ever land in border-row windows, so their value is irrelevant.
    always_comb begin
        new_pix       = (state == ST_FLUSH) ? 8'h00 : gray;
        primed        = (srow > RW'(1)) || ((srow == RW'(1)) && (scol != '0));
        frame_end     = (state == ST_FLUSH) && (srow == ROW_END);
        center_border = (crow == '0) || (crow == ROW_LAST) ||
                        (ccol == '0) || (ccol == COL_LAST);
        center_last   = (crow == ROW_LAST) && (ccol == COL_LAST);
    end

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            scol <= '0;
            srow <= '0;
            ccol <= '0;
            crow <= '0;
        end else if (step) begin
            if (frame_end) begin
                scol <= '0;
                srow <= '0;
                ccol <= '0;
                crow <= '0;
            end else begin
                if (scol == COL_LAST) begin
                    scol <= '0;
                    srow <= srow + RW'(1);
                end else begin
                    scol <= scol + CW'(1);
                end
                if (primed) begin
                    if (ccol == COL_LAST) begin
                        ccol <= '0;
                        crow <= crow + RW'(1);
                    end else begin
                        ccol <= ccol + CW'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and 3x3 window (data only, no reset needed)
    // lb0 holds the previous row, lb1 the row before that.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (step) begin
            lb1[scol] <= lb0[scol];
            lb0[scol] <= new_pix;
            for (int unsigned i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb1[scol];
            win[1][2] <= lb0[scol];
            win[2][2] <= new_pix;
        end
    end

    // ------------------------------------------------------------------
    // Sobel magnitude from the window
    // ------------------------------------------------------------------
    function automatic logic signed [11:0] sx(input logic [7:0] v);
        return $signed({4'b0000, v});
    endfunction

    always_comb begin
        gx = sx(win[0][2]) + (sx(win[1][2]) <<< 1) + sx(win[2][2])
           - sx(win[0][0]) - (sx(win[1][0]) <<< 1) - sx(win[2][0]);
        gy = sx(win[2][0]) + (sx(win[2][1]) <<< 1) + sx(win[2][2])
           - sx(win[0][0]) - (sx(win[0][1]) <<< 1) - sx(win[0][2]);
        abs_gx  = gx[11] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy  = gy[11] ? $unsigned(-gy) : $unsigned(gy);
        mag_sum = abs_gx + abs_gy;
        mag     = (mag_sum > 12'd255) ? 8'hFF : mag_sum[7:0];
    end

    // ------------------------------------------------------------------
    // Pipeline stages; every stage freezes together while the output stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            v1      <= 1'b0;
            b1      <= 1'b0;
            l1      <= 1'b0;
            v2      <= 1'b0;
            l2      <= 1'b0;
            mag2    <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            pixel_o <= '0;
        end else if (!stall) begin
            v1      <= step && primed;
            b1      <= center_border;
            l1      <= center_last;
            v2      <= v1;
            l2      <= v1 && l1;
            mag2    <= b1 ? 8'h00 : mag;
            valid_o <= v2;
            last_o  <= l2;
            pixel_o <= {CHANNELS_P{mag2}};
        end
    end

endmodule

// File: tb/tb_sobel_pipeline.sv
// tb_sobel_pipeline: directed bench for sobel_pipeline (W=8, H=6, 3 channels).
// A convolution model over the recorded input frame predicts every output;
// literal spot values pin that model to hand-computed results.
module tb_sobel_pipeline;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clk;
    logic        resetn;
    logic        valid_i;
    logic        ready_o;
    logic [23:0] pixel_i;
    logic        valid_o;
    logic        ready_i;
    logic [23:0] pixel_o;
    logic        last_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int rdy_mode = 0;
    int gap_mode = 0;
    bit lat_chk  = 0;

    logic [23:0] in_img   [2][N];
    int          acc_edge [2][N];
    int          first_edge [2];
    int          in_idx, in_frame, out_k, out_frame;
    bit          prev_stall;
    logic [23:0] prev_pix;
    logic        prev_valid, prev_last;
    logic [23:0] out_cap [N];
    int          frames_done = 0;
    int          last_len    = 0;
    int          frame_time  = 0;

    sobel_pipeline #(.WIDTH_P(W), .HEIGHT_P(H), .CHANNELS_P(3)) dut (
        .clk_i   (clk),
        .resetn_i(resetn),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .pixel_i (pixel_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .pixel_o (pixel_o),
        .last_o  (last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h required=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gray_at(input int f, input int r, input int c);
        logic [23:0] p;
        p = in_img[f][r*W + c];
        return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
    endfunction

    function automatic logic [23:0] model_out(input int f, input int k);
        int r, c, gx, gy, m, wx, wy;
        r = k / W;
        c = k % W;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 24'h000000;
        gx = 0;
        gy = 0;
        for (int di = -1; di <= 1; di++) begin
            for (int dj = -1; dj <= 1; dj++) begin
                wx = dj * ((di == 0) ? 2 : 1);
                wy = di * ((dj == 0) ? 2 : 1);
                gx += wx * gray_at(f, r + di, c + dj);
                gy += wy * gray_at(f, r + di, c + dj);
            end
        end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 255) m = 255;
        return {3{8'(m)}};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!resetn) begin
            in_idx     = 0;
            in_frame   = 0;
            out_k      = 0;
            out_frame  = 0;
            prev_stall = 1'b0;
        end else begin
            if (valid_i && ready_o) begin
                in_img[in_frame][in_idx]   = pixel_i;
                acc_edge[in_frame][in_idx] = cyc + 1;
                if (in_idx == 0) first_edge[in_frame] = cyc + 1;
                if (in_idx == N-1) begin
                    in_idx   = 0;
                    in_frame = 1 - in_frame;
                end else begin
                    in_idx++;
                end
            end
            if (prev_stall) begin
                check("stall_pixel", pixel_o, prev_pix);
                check("stall_valid", valid_o, prev_valid);
                check("stall_last",  last_o,  prev_last);
            end
            if (valid_o && !ready_i) check("ready_in_stall", ready_o, 1'b0);
            if (valid_o && !prev_stall && lat_chk && (out_k + W + 1 < N)) begin
                check($sformatf("latency k=%0d", out_k), cyc,
                      acc_edge[out_frame][out_k + W + 1] + 2);
            end
            if (valid_o && ready_i) begin
                check($sformatf("pixel k=%0d", out_k), pixel_o, model_out(out_frame, out_k));
                check($sformatf("last k=%0d", out_k), last_o, (out_k == N-1));
                out_cap[out_k] = pixel_o;
                if (last_o || out_k == N-1) begin
                    last_len   = out_k + 1;
                    frame_time = cyc - first_edge[out_frame];
                    frames_done++;
                    out_k     = 0;
                    out_frame = 1 - out_frame;
                end else begin
                    out_k++;
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_pix   = pixel_o;
            prev_valid = valid_o;
            prev_last  = last_o;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [23:0] img(input int tid, input int idx);
        int c;
        c = idx % W;
        case (tid)
            1:       return 24'h808080;
            2:       return (c < 4) ? 24'h000000 : 24'hFFFFFF;
            3:       return 24'(24'h0A0A0A * c);
            default: return 24'h000000;
        endcase
    endfunction

    // Entered and left at posedge+1.
    task automatic send_pixel(input logic [23:0] p);
        int t;
        pixel_i = p;
        valid_i = 1'b1;
        t = 0;
        @(negedge clk);
        while (!ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ready_o) check("accept_timeout", ready_o, 1'b1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_pixels(input int tid, input int count);
        for (int i = 0; i < count; i++) begin
            if (gap_mode != 0 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_pixel(img(tid, i));
        end
    endtask

    task automatic wait_frame(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("frame_done", (frames_done >= target), 1'b1);
        @(posedge clk);
        #1;
    endtask

    int fd0;

    initial begin
        resetn  = 1'b0;
        valid_i = 1'b0;
        pixel_i = '0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_valid", valid_o, 1'b0);
        check("rst_last",  last_o,  1'b0);
        check("rst_pixel", pixel_o, 24'h0);
        check("rst_ready", ready_o, 1'b0);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 1: uniform image, full rate, flush window check
        lat_chk = 1;
        fd0 = frames_done;
        send_pixels(1, N);
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            check($sformatf("flush_ready %0d", i), ready_o, 1'b0);
        end
        @(negedge clk);
        check("ready_after_flush", ready_o, 1'b1);
        @(posedge clk);
        #1;
        wait_frame(fd0 + 1);
        check("t1_len", last_len, N);
        check("t1_px27", out_cap[27], 24'h000000);
        checks++;
        if (frame_time > N + W + 4) begin
            failures++;
            $display("FAIL frame_time: got=%0d required<=%0d", frame_time, N + W + 4);
        end

        // 2: vertical step
        fd0 = frames_done;
        send_pixels(2, N);
        wait_frame(fd0 + 1);
        check("t2_r1c3", out_cap[1*W + 3], 24'hFFFFFF);
        check("t2_r4c4", out_cap[4*W + 4], 24'hFFFFFF);
        check("t2_r2c2", out_cap[2*W + 2], 24'h000000);
        check("t2_r0c3", out_cap[0*W + 3], 24'h000000);

        // 3: ramp
        fd0 = frames_done;
        send_pixels(3, N);
        wait_frame(fd0 + 1);
        check("t3_r2c3", out_cap[2*W + 3], 24'h505050);
        check("t3_r4c6", out_cap[4*W + 6], 24'h505050);
        check("t3_r1c7", out_cap[1*W + 7], 24'h000000);

        // 4: random backpressure on the step image
        rdy_mode = 1;
        lat_chk  = 0;
        fd0 = frames_done;
        send_pixels(2, N);
        wait_frame(fd0 + 1);
        check("t4_len",   last_len, N);
        check("t4_r3c4",  out_cap[3*W + 4], 24'hFFFFFF);
        check("t4_r3c5",  out_cap[3*W + 5], 24'h000000);

        // 5: random input gaps, ready held high
        rdy_mode = 0;
        @(posedge clk);
        #1;
        gap_mode = 1;
        lat_chk  = 1;
        fd0 = frames_done;
        send_pixels(3, N);
        wait_frame(fd0 + 1);
        check("t5_r3c2", out_cap[3*W + 2], 24'h505050);
        gap_mode = 0;

        // 6: reset mid-frame, then a full black frame
        send_pixels(3, 20);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_last",  last_o,  1'b0);
        check("mid_rst_pixel", pixel_o, 24'h0);
        check("mid_rst_ready", ready_o, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        fd0 = frames_done;
        send_pixels(0, N);
        wait_frame(fd0 + 1);
        check("t6_len", last_len, N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
